// File: rtl/mem_req_pkg.sv
// Shared opcodes, state encoding and width defaults for the nRisc MEM-stage requester.
package mem_req_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 8;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b100;
  localparam logic [2:0] OP_LOAD  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  function automatic logic is_mem_op(input logic [2:0] op);
    return (op == OP_STORE) || (op == OP_LOAD);
  endfunction

endpackage

// File: rtl/mem_req_fwd_buf.sv
// One-entry last-store buffer with address match, used for store-to-load forwarding.
module mem_req_fwd_buf
  import mem_req_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data
);

  logic              entry_valid;
  logic [ADDR_W-1:0] entry_addr;
  logic [DATA_W-1:0] entry_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      entry_valid <= 1'b0;
      entry_addr  <= '0;
      entry_data  <= '0;
    end else if (wr_en) begin
      entry_valid <= 1'b1;
      entry_addr  <= wr_addr;
      entry_data  <= wr_data;
    end
  end

  always_comb begin
    hit      = entry_valid && (entry_addr == lookup_addr);
    hit_data = entry_data;
  end

endmodule

// File: rtl/mem_requester.sv
// MEM-stage initiator sequencing one-edge synchronous data-memory accesses.
// Optional store-to-load forwarding is enabled by defining MEM_REQ_FWD_EN.
module mem_requester
  import mem_req_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [DATA_W-1:0] req_data,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [2:0]        mem_instruction,
  output logic [DATA_W-1:0] mem_index_a,
  output logic [ADDR_W-1:0] mem_index_b,
  input  logic [DATA_W-1:0] mem_solution,
  output logic              busy
);

  state_t            state;
  logic              accept;
  logic              load_hit;
  logic [DATA_W-1:0] hit_data;

  assign accept = (state == ST_IDLE) && req_valid;

`ifdef MEM_REQ_FWD_EN
  logic fwd_hit;

  mem_req_fwd_buf #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fwd_buf (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (accept && (req_op == OP_STORE)),
    .wr_addr     (req_addr),
    .wr_data     (req_data),
    .lookup_addr (req_addr),
    .hit         (fwd_hit),
    .hit_data    (hit_data)
  );

  assign load_hit = fwd_hit && (req_op == OP_LOAD);
`else
  assign load_hit = 1'b0;
  assign hit_data = '0;
`endif

  // mem_instruction doubles as the record of the in-flight op during ISSUE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= ST_IDLE;
      req_ready       <= 1'b1;
      busy            <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_data        <= '0;
      mem_instruction <= OP_NOP;
      mem_index_a     <= '0;
      mem_index_b     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (load_hit) begin
              state     <= ST_RESP;
              req_ready <= 1'b0;
              busy      <= 1'b1;
              rsp_valid <= 1'b1;
              rsp_data  <= hit_data;
            end else if (is_mem_op(req_op)) begin
              state           <= ST_ISSUE;
              req_ready       <= 1'b0;
              busy            <= 1'b1;
              mem_instruction <= req_op;
              mem_index_a     <= req_data;
              mem_index_b     <= req_addr;
            end
          end
        end
        ST_ISSUE: begin
          mem_instruction <= OP_NOP;
          if (mem_instruction == OP_STORE) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          state     <= ST_RESP;
          rsp_data  <= mem_solution;
          rsp_valid <= 1'b1;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_requester.sv
// Randomized self-checking bench for mem_requester against a transaction-level model
// with a behavioural one-edge data memory. Honours MEM_REQ_FWD_EN when defined.
module tb_mem_requester;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [7:0] req_data;
  logic [7:0] req_addr;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [2:0] mem_instruction;
  logic [7:0] mem_index_a;
  logic [7:0] mem_index_b;
  logic [7:0] mem_solution;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem_arr [256];
  logic [7:0] ref_mem [256];
  logic       last_valid;
  logic [7:0] last_addr;

  always #5 clock = ~clock;

  mem_requester #(.ADDR_W(8), .DATA_W(8)) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_data        (req_data),
    .req_addr        (req_addr),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_data        (rsp_data),
    .mem_instruction (mem_instruction),
    .mem_index_a     (mem_index_a),
    .mem_index_b     (mem_index_b),
    .mem_solution    (mem_solution),
    .busy            (busy)
  );

  // Data memory: acts on the edge closing a cycle that carries an opcode, no reset.
  always @(posedge clock) begin
    if (mem_instruction == 3'b100) mem_arr[mem_index_b] <= mem_index_a;
    mem_solution <= (mem_instruction == 3'b101) ? mem_arr[mem_index_b] : 8'h00;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    check_eq({tag, ".busy"}, 32'(busy), 32'd0);
    check_eq({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, ".mem_instr"}, 32'(mem_instruction), 32'd0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    last_valid = 1'b0;
  endtask

  // One request through the DUT; expectations come from ref_mem and the last-store record.
  task automatic do_req(input logic [2:0] op, input logic [7:0] addr,
                        input logic [7:0] data, input int rsp_delay);
    int  n;
    int  lat;
    logic hit;
    logic [7:0] exp;
    n = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_data  = data;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    check_eq("accept_wait", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    req_op    = 3'b000;

    if (op == 3'b100) begin
      check_eq("st_issue.instr", 32'(mem_instruction), 32'd4);
      check_eq("st_issue.idx_b", 32'(mem_index_b), 32'(addr));
      check_eq("st_issue.idx_a", 32'(mem_index_a), 32'(data));
      check_eq("st_issue.busy", 32'(busy), 32'd1);
      check_eq("st_issue.req_ready", 32'(req_ready), 32'd0);
      step();
      check_idle("st_done");
      ref_mem[addr] = data;
      last_valid = 1'b1;
      last_addr  = addr;
    end else if (op == 3'b101) begin
`ifdef MEM_REQ_FWD_EN
      hit = last_valid && (last_addr == addr);
`else
      hit = 1'b0;
`endif
      lat = hit ? 1 : 3;
      exp = ref_mem[addr];
      if (hit) check_eq("ld_fwd.instr", 32'(mem_instruction), 32'd0);
      else begin
        check_eq("ld_issue.instr", 32'(mem_instruction), 32'd5);
        check_eq("ld_issue.idx_b", 32'(mem_index_b), 32'(addr));
      end
      n = 1;
      while (!rsp_valid && n < 10) begin
        step();
        n++;
        check_eq("ld_wait.instr", 32'(mem_instruction), 32'd0);
      end
      check_eq("ld_latency", 32'(n), 32'(lat));
      if (!rsp_valid) begin
        apply_reset();
        return;
      end
      check_eq("ld_data", 32'(rsp_data), 32'(exp));
      for (int i = 0; i < rsp_delay; i++) begin
        step();
        check_eq("bp.rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("bp.rsp_data", 32'(rsp_data), 32'(exp));
        check_eq("bp.req_ready", 32'(req_ready), 32'd0);
        check_eq("bp.busy", 32'(busy), 32'd1);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check_idle("ld_done");
    end else begin
      check_idle("noop");
      step();
      check_idle("noop2");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] op;
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    req_op = 3'b000;
    req_data = 8'h00;
    req_addr = 8'h00;
    #1;
    apply_reset();

    check_idle("reset");
    check_eq("reset.rsp_data", 32'(rsp_data), 32'd0);
    check_eq("reset.idx_a", 32'(mem_index_a), 32'd0);
    check_eq("reset.idx_b", 32'(mem_index_b), 32'd0);

    do_req(3'b100, 8'h10, 8'h5A, 0);
    do_req(3'b101, 8'h10, 8'h00, 0);
    do_req(3'b101, 8'h10, 8'h00, 5);
    do_req(3'b010, 8'h33, 8'h77, 0);
    do_req(3'b100, 8'h22, 8'hA5, 0);
    do_req(3'b101, 8'h22, 8'h00, 1);
    do_req(3'b101, 8'h10, 8'h00, 0);

    // Reset during CAPTURE of a load: response must never appear.
    do_req(3'b100, 8'h44, 8'h3C, 0);
    req_valid = 1'b1;
    req_op = 3'b101;
    req_addr = 8'h44;
    step();
    req_valid = 1'b0;
    req_op = 3'b000;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    last_valid = 1'b0;
    check_idle("rst_cap");
    check_eq("rst_cap.rsp_data", 32'(rsp_data), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("rst_cap.no_rsp", 32'(rsp_valid), 32'd0);
    end
    do_req(3'b101, 8'h44, 8'h00, 0);

    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: op = 3'b100;
        4, 5, 6, 7: op = 3'b101;
        default: op = $urandom_range(0, 1) ? 3'($urandom_range(0, 3))
                                           : {2'b11, 1'($urandom_range(0, 1))};
      endcase
      do_req(op, 8'($urandom_range(0, 15)) | (($urandom_range(0, 7) == 0) ? 8'hF0 : 8'h00),
             8'($urandom), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
